// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: W-bit unsigned binary to four BCD digits,
// one bit per clock, start/busy/done handshake, results held between conversions.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin_to_bcd_seq #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic [3:0]   dig3,
    output logic [3:0]   dig2,
    output logic [3:0]   dig1,
    output logic [3:0]   dig0
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  sh;
    logic [15:0]   scr;
    logic [CW-1:0] cnt;
    logic          ovf_pend;

    logic [11:0]   adj;
    logic [2:0]    top_adj;
    logic [15:0]   scr_nx;
    logic [W-1:0]  sh_nx;
    logic [13:0]   bin_ext;
    logic          accept, last;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_add3
            bcd_add3 u_add3 (.d(scr[4*g +: 4]), .q(adj[4*g +: 4]));
        end
    endgenerate

    // Top nibble's MSB is shifted out anyway, so only its low 3 adjusted bits matter.
    assign top_adj = (scr[15:12] >= 4'd5) ? scr[14:12] + 3'd3 : scr[14:12];
    assign scr_nx  = {top_adj, adj, sh[W-1]};
    assign sh_nx   = {sh[W-2:0], 1'b0};
    assign bin_ext = 14'(bin);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(1)) begin
                    last     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sh       <= '0;
            scr      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            dig3     <= '0;
            dig2     <= '0;
            dig1     <= '0;
            dig0     <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                sh       <= bin;
                scr      <= '0;
                cnt      <= CW'(W);
                busy     <= 1'b1;
                ovf_pend <= (bin_ext > 14'd9999);
            end else if (state == SHIFT) begin
                sh  <= sh_nx;
                scr <= scr_nx;
                cnt <= cnt - CW'(1);
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    ovf  <= ovf_pend;
                    {dig3, dig2, dig1, dig0} <= ovf_pend ? 16'hFFFF : scr_nx;
                end
            end
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized self-checking bench for bin_to_bcd_seq against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;
    localparam int W = 14;

    logic         clk = 1'b0;
    logic         clr_n;
    logic         start;
    logic [W-1:0] bin;
    logic         busy, done, ovf;
    logic [3:0]   dig3, dig2, dig1, dig0;

    int tests = 0;
    int fails = 0;

    bin_to_bcd_seq #(.W(W)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .bin(bin),
        .busy(busy), .done(done), .ovf(ovf),
        .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_digs(input int v);
        if (v > 9999) return 16'hFFFF;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] digs();
        return {dig3, dig2, dig1, dig0};
    endfunction

    // Caller is aligned 1 time unit after a rising edge with the FSM idle.
    task automatic convert(input string name, input int v);
        int          lat;
        bit          busy_bad, hold_bad;
        logic [15:0] prev;
        prev     = digs();
        busy_bad = 0;
        hold_bad = 0;
        start = 1'b1;
        bin   = W'(v);
        @(posedge clk); #1;
        start = 1'b0;
        bin   = W'($urandom);
        lat   = 0;
        while (!done && lat < 40) begin
            if (!busy) busy_bad = 1;
            if (digs() !== prev) hold_bad = 1;
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat !== W) begin
            fails++;
            $display("FAIL %s latency v=%0d got %0d exp %0d", name, v, lat, W);
        end
        tests++;
        if (digs() !== ref_digs(v)) begin
            fails++;
            $display("FAIL %s digits v=%0d got %h exp %h", name, v, digs(), ref_digs(v));
        end
        tests++;
        if (ovf !== (v > 9999)) begin
            fails++;
            $display("FAIL %s ovf v=%0d got %b exp %b", name, v, ovf, v > 9999);
        end
        tests++;
        if (busy_bad || hold_bad || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s handshake v=%0d got busy_gap=%b hold_change=%b busy_at_done=%b exp 0 0 0",
                     name, v, busy_bad, hold_bad, busy);
        end
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || digs() !== ref_digs(v)) begin
            fails++;
            $display("FAIL %s after_done got done=%b dig=%h exp done=0 dig=%h", name, done, digs(), ref_digs(v));
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        #2;
        tests++;
        if ({busy, done, ovf, digs()} !== 19'd0) begin
            fails++;
            $display("FAIL reset_async got %h exp 0", {busy, done, ovf, digs()});
        end
        start = 1'b1;
        bin   = W'(1234);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, ovf, digs()} !== 19'd0) begin
            fails++;
            $display("FAIL reset_hold got %h exp 0", {busy, done, ovf, digs()});
        end
        start = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_release got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        convert("basic_1234", 1234);
    endtask

    task automatic test_boundaries();
        convert("bnd_0", 0);
        convert("bnd_9999", 9999);
        convert("bnd_10000", 10000);
        convert("bnd_16383", 16383);
        convert("bnd_42", 42);
        convert("bnd_1", 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            if (i % 4 == 0) convert("rand_ovf", int'($urandom_range(10000, 16383)));
            else            convert("rand", int'($urandom_range(0, 9999)));
        end
    endtask

    task automatic test_busy_ignore();
        int          ndone;
        bit          hold_bad;
        logic [15:0] prev, got;
        prev     = digs();
        ndone    = 0;
        hold_bad = 0;
        got      = '0;
        start = 1'b1;
        bin   = W'(5678);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                got = digs();
            end else if (ndone == 0 && digs() !== prev) begin
                hold_bad = 1;
            end
            if (i == 5) begin
                start = 1'b1;
                bin   = W'(1111);
            end
            if (i == 6) start = 1'b0;
        end
        tests++;
        if (ndone !== 1) begin
            fails++;
            $display("FAIL busy_ignore done_count got %0d exp 1", ndone);
        end
        tests++;
        if (got !== 16'h5678 || digs() !== 16'h5678 || hold_bad) begin
            fails++;
            $display("FAIL busy_ignore digits got %h/%h hold_change=%b exp 5678/5678 0", got, digs(), hold_bad);
        end
    endtask

    task automatic test_back_to_back();
        int vals[7] = '{100, 250, 100, 250, 100, 250, 100};
        int lat;
        start = 1'b1;
        bin   = W'(vals[0]);
        @(posedge clk); #1;
        bin = W'(vals[1]);
        for (int k = 0; k < 5; k++) begin
            lat = 0;
            while (!done && lat < 40) begin
                @(posedge clk); #1;
                lat++;
                if (!done && !busy) lat = 100;
            end
            tests++;
            if (lat !== W || digs() !== ref_digs(vals[k]) || busy !== 1'b0 || ovf !== 1'b0) begin
                fails++;
                $display("FAIL b2b_%0d got lat=%0d dig=%h busy=%b ovf=%b exp lat=%0d dig=%h busy=0 ovf=0",
                         k, lat, digs(), busy, ovf, W, ref_digs(vals[k]));
            end
            @(posedge clk); #1;
            tests++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL b2b_reaccept_%0d got done=%b busy=%b exp 0 1", k, done, busy);
            end
            bin = W'(vals[k + 2]);
        end
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat !== W || digs() !== ref_digs(vals[5])) begin
            fails++;
            $display("FAIL b2b_tail got lat=%0d dig=%h exp %0d %h", lat, digs(), W, ref_digs(vals[5]));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int ndone;
        start = 1'b1;
        bin   = W'(4321);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        clr_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, ovf, digs()} !== 19'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs got %h exp 0", {busy, done, ovf, digs()});
        end
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        tests++;
        if (ndone !== 0 || busy !== 1'b0 || digs() !== 16'h0000) begin
            fails++;
            $display("FAIL reset_mid_abort got done_count=%0d busy=%b dig=%h exp 0 0 0000", ndone, busy, digs());
        end
        convert("post_reset", int'($urandom_range(0, 9999)));
        convert("post_reset_ovf", 12345);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
